// File: rtl/a_line_acq_pp.sv
// A-line acquisition with line averaging into a ping-pong accumulator memory.
// One bank accumulates the current frame while the other streams its averaged samples out.
module a_line_acq_pp #(
    parameter int DATA_W   = 14,
    parameter int NSAMPLES = 1170,
    parameter int ADDR_W   = 11,
    parameter int AVG_LOG2 = 3
) (
    input  logic              clk_system,
    input  logic              global_reset,
    input  logic              trigger,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_valid,
    input  logic [2:0]        avg_sel,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              acq_busy,
    output logic              frame_drop,
    output logic              trig_miss
);

    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NSAMPLES - 1);
    localparam logic [2:0]        NAVG_MAX = 3'(AVG_LOG2);

    typedef enum logic [1:0] {IDLE, CAPTURE, SWAP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          navg_q, navg_d;
    logic                wbank_q, wbank_d;
    logic                busy_q, busy_d;
    logic                miss_q, miss_d;
    logic                drop_q, drop_d;
    logic [2:0]          sync_q;
    logic                trig_edge;
    logic                start_rd;
    logic                mem_we;
    logic [2:0]          navg_sel;
    logic [CNT_W-1:0]    line_target;

    logic                rbank_q;
    logic                rd_busy_q;
    logic                fetch_pend_q;
    logic [ADDR_W-1:0]   raddr_q;
    logic                rd_vld_q;
    logic                rd_last_q;
    logic [2:0]          rd_navg_q;
    logic [ACC_W-1:0]    rd_acc_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_valid_q;
    logic                out_last_q;
    logic                out_fire;
    logic                load_out;
    logic                fetch;

    logic [ACC_W-1:0]    mem [0:2*DEPTH-1];
    logic [ADDR_W:0]     waddr;
    logic [ADDR_W:0]     raddr_full;
    logic [ACC_W-1:0]    sample_ext;

    // sync_q[1:0] is the synchroniser, sync_q[2] the edge-detect delay flop
    assign trig_edge   = sync_q[1] & ~sync_q[2];
    assign navg_sel    = (avg_sel > NAVG_MAX) ? NAVG_MAX : avg_sel;
    assign line_target = CNT_W'(1) << navg_q;
    assign sample_ext  = ACC_W'(adc_data);
    assign waddr       = {wbank_q, idx_q};
    assign raddr_full  = {rbank_q, raddr_q};

    always_ff @(posedge clk_system or negedge global_reset) begin
        if (!global_reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            navg_q  <= '0;
            wbank_q <= 1'b0;
            busy_q  <= 1'b0;
            miss_q  <= 1'b0;
            drop_q  <= 1'b0;
            sync_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            navg_q  <= navg_d;
            wbank_q <= wbank_d;
            busy_q  <= busy_d;
            miss_q  <= miss_d;
            drop_q  <= drop_d;
            sync_q  <= {sync_q[1:0], trigger};
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        navg_d   = navg_q;
        wbank_d  = wbank_q;
        busy_d   = busy_q;
        miss_d   = 1'b0;
        drop_d   = 1'b0;
        start_rd = 1'b0;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig_edge) begin
                    state_d = CAPTURE;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    if (cnt_q == '0) navg_d = navg_sel;
                end
            end
            CAPTURE: begin
                miss_d = trig_edge;
                if (adc_valid) begin
                    mem_we = 1'b1;
                    idx_d  = idx_q + ADDR_W'(1);
                    if (idx_q == LAST_IDX) begin
                        cnt_d   = cnt_q + CNT_W'(1);
                        busy_d  = 1'b0;
                        state_d = (cnt_d == line_target) ? SWAP : IDLE;
                    end
                end
            end
            SWAP: begin
                miss_d  = trig_edge;
                cnt_d   = '0;
                state_d = IDLE;
                if (rd_busy_q) begin
                    drop_d = 1'b1;
                end else begin
                    start_rd = 1'b1;
                    wbank_d  = ~wbank_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-stage read pipeline: registered memory read, then the output beat register
    assign out_fire = out_valid_q & out_ready;
    assign load_out = rd_vld_q & (~out_valid_q | out_fire);
    assign fetch    = fetch_pend_q & (~rd_vld_q | load_out);

    always_ff @(posedge clk_system or negedge global_reset) begin
        if (!global_reset) begin
            rbank_q      <= 1'b0;
            rd_busy_q    <= 1'b0;
            fetch_pend_q <= 1'b0;
            raddr_q      <= '0;
            rd_vld_q     <= 1'b0;
            rd_last_q    <= 1'b0;
            rd_navg_q    <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            if (start_rd) begin
                rbank_q      <= wbank_q;
                rd_busy_q    <= 1'b1;
                fetch_pend_q <= 1'b1;
                raddr_q      <= '0;
                rd_navg_q    <= navg_q;
            end else if (fetch) begin
                raddr_q <= raddr_q + ADDR_W'(1);
                if (raddr_q == LAST_IDX) fetch_pend_q <= 1'b0;
            end
            if (fetch) begin
                rd_vld_q  <= 1'b1;
                rd_last_q <= (raddr_q == LAST_IDX);
            end else if (load_out) begin
                rd_vld_q <= 1'b0;
            end
            if (load_out) begin
                out_valid_q <= 1'b1;
                out_data_q  <= DATA_W'(rd_acc_q >> rd_navg_q);
                out_last_q  <= rd_last_q;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
            if (out_fire && out_last_q) rd_busy_q <= 1'b0;
        end
    end

    // Memory is never reset: line 0 of every frame overwrites each location before use
    always_ff @(posedge clk_system) begin
        if (mem_we) mem[waddr] <= (cnt_q == '0) ? sample_ext : mem[waddr] + sample_ext;
        if (fetch) rd_acc_q <= mem[raddr_full];
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign acq_busy   = busy_q;
    assign frame_drop = drop_q;
    assign trig_miss  = miss_q;

endmodule

// File: tb/tb_a_line_acq_pp.sv
// Directed testbench for a_line_acq_pp with 8-sample lines.
// Inputs change 2 ns after the rising edge; a falling-edge monitor records beats and status pulses.
module tb_a_line_acq_pp;

    localparam int DW = 14;
    localparam int NS = 8;
    localparam int AW = 3;
    localparam int AL = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          trigger   = 1'b0;
    logic [DW-1:0] adc_data  = '0;
    logic          adc_valid = 1'b0;
    logic [2:0]    avg_sel   = '0;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_last;
    logic          acq_busy;
    logic          frame_drop;
    logic          trig_miss;

    int checks   = 0;
    int failures = 0;

    int beatData[$];
    bit beatLast[$];
    int missHigh = 0, missRise = 0, dropHigh = 0, dropRise = 0, busyRise = 0;
    logic prevMiss = 1'b0, prevDrop = 1'b0, prevBusy = 1'b0, prevStall = 1'b0;
    logic [DW-1:0] prevData = '0;
    logic prevLast = 1'b0;

    a_line_acq_pp #(
        .DATA_W(DW), .NSAMPLES(NS), .ADDR_W(AW), .AVG_LOG2(AL)
    ) dut (
        .clk_system(clk), .global_reset(rst_n), .trigger(trigger),
        .adc_data(adc_data), .adc_valid(adc_valid), .avg_sel(avg_sel),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .acq_busy(acq_busy), .frame_drop(frame_drop),
        .trig_miss(trig_miss)
    );

    always #5 clk = ~clk;

    // Record every transfer, check stability while stalled, and count status pulses
    always @(negedge clk) begin
        if (rst_n) begin
            if (prevStall && out_valid) begin
                checks++;
                if (out_data !== prevData || out_last !== prevLast) begin
                    failures++;
                    $display("[TB] FAIL stall_stable: data=%0d last=%0b, required data=%0d last=%0b",
                             out_data, out_last, prevData, prevLast);
                end
            end
            prevStall = out_valid && !out_ready;
            prevData  = out_data;
            prevLast  = out_last;
            if (out_valid && out_ready) begin
                beatData.push_back(int'(out_data));
                beatLast.push_back(out_last);
            end
        end else begin
            prevStall = 1'b0;
        end
        if (trig_miss) missHigh++;
        if (trig_miss && !prevMiss) missRise++;
        if (frame_drop) dropHigh++;
        if (frame_drop && !prevDrop) dropRise++;
        if (acq_busy && !prevBusy) busyRise++;
        prevMiss = trig_miss;
        prevDrop = frame_drop;
        prevBusy = acq_busy;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_beats();
        beatData.delete();
        beatLast.delete();
    endtask

    task automatic capture_line(input int base, input int incr, input bit gap,
                                input int missAt, output int busyCnt);
        int t, i, k, trigTimer;
        bit trigDone;
        busyCnt   = 0;
        trigger   = 1'b1;
        repeat (3) tick();
        trigger   = 1'b0;
        t = 0;
        while (!acq_busy && t < 10) begin
            tick();
            t++;
        end
        if (!acq_busy) begin
            checks++;
            failures++;
            $display("[TB] FAIL capture_start: acq_busy=%0b after %0d cycles, required 1", acq_busy, t);
            return;
        end
        i = 0; k = 0; trigTimer = 0; trigDone = 1'b0;
        while (i < NS && k < 40) begin
            if (acq_busy) busyCnt++;
            if (missAt >= 0 && i == missAt && !trigDone) begin
                trigger   = 1'b1;
                trigTimer = 3;
                trigDone  = 1'b1;
            end
            if (gap && (k % 2 == 1)) begin
                adc_valid = 1'b0;
            end else begin
                adc_valid = 1'b1;
                adc_data  = DW'(base + i * incr);
                i++;
            end
            tick();
            k++;
            if (trigTimer > 0) begin
                trigTimer--;
                if (trigTimer == 0) trigger = 1'b0;
            end
        end
        adc_valid = 1'b0;
        trigger   = 1'b0;
    endtask

    task automatic wait_beats(input int n, input bit randReady);
        int t = 0;
        while (beatData.size() < n && t < 200) begin
            if (randReady) out_ready = 1'($urandom_range(0, 1));
            tick();
            t++;
        end
        checks++;
        if (beatData.size() < n) begin
            failures++;
            $display("[TB] FAIL beat_timeout: got %0d beats, required %0d", beatData.size(), n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        checks += 6;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: %b, required 0", out_valid); end
        if (out_last !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_last: %b, required 0", out_last); end
        if (out_data !== '0) begin failures++; $display("[TB] FAIL reset_out_data: %0d, required 0", out_data); end
        if (acq_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_acq_busy: %b, required 0", acq_busy); end
        if (frame_drop !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame_drop: %b, required 0", frame_drop); end
        if (trig_miss !== 1'b0) begin failures++; $display("[TB] FAIL reset_trig_miss: %b, required 0", trig_miss); end
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_single_line();
        int bc;
        avg_sel   = 3'd0;
        out_ready = 1'b1;
        clear_beats();
        capture_line(0, 1, 1'b0, -1, bc);
        checks += 2;
        if (bc != 8) begin failures++; $display("[TB] FAIL single_busy_cycles: %0d, required 8", bc); end
        if (acq_busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_end: %b, required 0", acq_busy); end
        wait_beats(NS, 1'b0);
        for (int j = 0; j < NS; j++) begin
            checks++;
            if (j >= beatData.size() || beatData[j] != j || beatLast[j] != (j == NS - 1)) begin
                failures++;
                $display("[TB] FAIL single_beat%0d: data=%0d last=%0b, required data=%0d last=%0b",
                         j, (j < beatData.size()) ? beatData[j] : -1,
                         (j < beatLast.size()) ? beatLast[j] : 1'b0, j, (j == NS - 1));
            end
        end
        repeat (3) tick();
        checks += 2;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_valid_drop: %b, required 0", out_valid); end
        if (beatData.size() != NS) begin failures++; $display("[TB] FAIL single_beat_count: %0d, required %0d", beatData.size(), NS); end
    endtask

    task automatic test_average();
        int bc;
        avg_sel   = 3'd2;
        out_ready = 1'b1;
        clear_beats();
        capture_line(100, 0, 1'b0, -1, bc);
        avg_sel = 3'd0;
        capture_line(101, 0, 1'b0, -1, bc);
        capture_line(102, 0, 1'b0, -1, bc);
        repeat (5) tick();
        checks += 2;
        if (beatData.size() != 0) begin failures++; $display("[TB] FAIL avg_early_beats: %0d, required 0", beatData.size()); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL avg_early_valid: %b, required 0", out_valid); end
        capture_line(103, 0, 1'b0, -1, bc);
        wait_beats(NS, 1'b0);
        for (int j = 0; j < NS; j++) begin
            checks++;
            if (j >= beatData.size() || beatData[j] != 101 || beatLast[j] != (j == NS - 1)) begin
                failures++;
                $display("[TB] FAIL avg_beat%0d: data=%0d, required 101", j,
                         (j < beatData.size()) ? beatData[j] : -1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int bc, d0, r0;
        avg_sel   = 3'd0;
        out_ready = 1'b0;
        clear_beats();
        d0 = dropHigh;
        r0 = dropRise;
        capture_line(10, 1, 1'b0, -1, bc);
        repeat (4) tick();
        checks++;
        if (out_valid !== 1'b1 || out_data !== DW'(10)) begin
            failures++;
            $display("[TB] FAIL b2b_first_beat: valid=%b data=%0d, required valid=1 data=10", out_valid, out_data);
        end
        capture_line(20, 1, 1'b0, -1, bc);
        repeat (4) tick();
        checks += 3;
        if (dropHigh - d0 != 1) begin failures++; $display("[TB] FAIL b2b_drop_cycles: %0d, required 1", dropHigh - d0); end
        if (dropRise - r0 != 1) begin failures++; $display("[TB] FAIL b2b_drop_pulses: %0d, required 1", dropRise - r0); end
        if (out_data !== DW'(10)) begin failures++; $display("[TB] FAIL b2b_stalled_data: %0d, required 10", out_data); end
        out_ready = 1'b1;
        wait_beats(NS, 1'b0);
        for (int j = 0; j < NS; j++) begin
            checks++;
            if (j >= beatData.size() || beatData[j] != 10 + j || beatLast[j] != (j == NS - 1)) begin
                failures++;
                $display("[TB] FAIL b2b_line1_beat%0d: data=%0d, required %0d", j,
                         (j < beatData.size()) ? beatData[j] : -1, 10 + j);
            end
        end
        clear_beats();
        capture_line(30, 1, 1'b0, -1, bc);
        wait_beats(NS, 1'b0);
        for (int j = 0; j < NS; j++) begin
            checks++;
            if (j >= beatData.size() || beatData[j] != 30 + j || beatLast[j] != (j == NS - 1)) begin
                failures++;
                $display("[TB] FAIL b2b_line3_beat%0d: data=%0d, required %0d", j,
                         (j < beatData.size()) ? beatData[j] : -1, 30 + j);
            end
        end
        checks++;
        if (dropHigh - d0 != 1) begin failures++; $display("[TB] FAIL b2b_drop_total: %0d, required 1", dropHigh - d0); end
    endtask

    task automatic test_trig_miss();
        int bc, m0, mr0, b0;
        avg_sel   = 3'd0;
        out_ready = 1'b1;
        clear_beats();
        m0  = missHigh;
        mr0 = missRise;
        b0  = busyRise;
        capture_line(70, 1, 1'b0, 3, bc);
        wait_beats(NS, 1'b0);
        repeat (20) tick();
        checks += 5;
        if (bc != 8) begin failures++; $display("[TB] FAIL miss_busy_cycles: %0d, required 8", bc); end
        if (missHigh - m0 != 1) begin failures++; $display("[TB] FAIL miss_cycles: %0d, required 1", missHigh - m0); end
        if (missRise - mr0 != 1) begin failures++; $display("[TB] FAIL miss_pulses: %0d, required 1", missRise - mr0); end
        if (busyRise - b0 != 1) begin failures++; $display("[TB] FAIL miss_lines_started: %0d, required 1", busyRise - b0); end
        if (beatData.size() != NS) begin failures++; $display("[TB] FAIL miss_beat_count: %0d, required %0d", beatData.size(), NS); end
        for (int j = 0; j < NS; j++) begin
            checks++;
            if (j >= beatData.size() || beatData[j] != 70 + j) begin
                failures++;
                $display("[TB] FAIL miss_beat%0d: data=%0d, required %0d", j,
                         (j < beatData.size()) ? beatData[j] : -1, 70 + j);
            end
        end
    endtask

    task automatic test_valid_toggle();
        int bc;
        avg_sel   = 3'd0;
        out_ready = 1'b0;
        clear_beats();
        capture_line(40, 3, 1'b1, -1, bc);
        checks++;
        if (bc != 15) begin failures++; $display("[TB] FAIL toggle_busy_cycles: %0d, required 15", bc); end
        wait_beats(NS, 1'b1);
        out_ready = 1'b1;
        repeat (5) tick();
        checks++;
        if (beatData.size() != NS) begin failures++; $display("[TB] FAIL toggle_beat_count: %0d, required %0d", beatData.size(), NS); end
        for (int j = 0; j < NS; j++) begin
            checks++;
            if (j >= beatData.size() || beatData[j] != 40 + 3 * j || beatLast[j] != (j == NS - 1)) begin
                failures++;
                $display("[TB] FAIL toggle_beat%0d: data=%0d, required %0d", j,
                         (j < beatData.size()) ? beatData[j] : -1, 40 + 3 * j);
            end
        end
    endtask

    task automatic test_reset_readout();
        int bc;
        avg_sel   = 3'd0;
        out_ready = 1'b1;
        clear_beats();
        capture_line(50, 1, 1'b0, -1, bc);
        wait_beats(4, 1'b0);
        rst_n = 1'b0;
        #1;
        checks += 3;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid: %b, required 0", out_valid); end
        if (out_data !== '0) begin failures++; $display("[TB] FAIL rst_mid_data: %0d, required 0", out_data); end
        if (acq_busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_busy: %b, required 0", acq_busy); end
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        checks += 2;
        if (beatData.size() != 4) begin failures++; $display("[TB] FAIL rst_beats_after: %0d, required 4", beatData.size()); end
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_valid_after: %b, required 0", out_valid); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (j >= beatData.size() || beatData[j] != 50 + j) begin
                failures++;
                $display("[TB] FAIL rst_pre_beat%0d: data=%0d, required %0d", j,
                         (j < beatData.size()) ? beatData[j] : -1, 50 + j);
            end
        end
        clear_beats();
        capture_line(60, 1, 1'b0, -1, bc);
        wait_beats(NS, 1'b0);
        repeat (3) tick();
        checks++;
        if (beatData.size() != NS) begin failures++; $display("[TB] FAIL rst_new_count: %0d, required %0d", beatData.size(), NS); end
        for (int j = 0; j < NS; j++) begin
            checks++;
            if (j >= beatData.size() || beatData[j] != 60 + j || beatLast[j] != (j == NS - 1)) begin
                failures++;
                $display("[TB] FAIL rst_new_beat%0d: data=%0d, required %0d", j,
                         (j < beatData.size()) ? beatData[j] : -1, 60 + j);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_line();
        test_average();
        test_back_to_back();
        test_trig_miss();
        test_valid_toggle();
        test_reset_readout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
